// File: rtl/clock_pkg.sv
// Shared types, field limits and reset values for the run-time time counter.
package clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned DAY_MIN  = 1;

    localparam int unsigned SEC_RST  = 0;
    localparam int unsigned MIN_RST  = 0;
    localparam int unsigned HOUR_RST = 0;
    localparam int unsigned DAY_RST  = DAY_MIN;

    // Numeric value of a digit pair; a ones digit above 9 counts as 9.
    function automatic logic [7:0] bcd_value(input bcd_t tens, input bcd_t ones);
        bcd_t ones_sat;
        ones_sat = (ones > 4'd9) ? 4'd9 : ones;
        return ({4'd0, tens} * 8'd10) + {4'd0, ones_sat};
    endfunction

endpackage

// File: rtl/time_counter_if.sv
// Set digits in from the time-set block, running time and pulses out to display.
interface time_counter_if;
    import clock_pkg::*;

    logic SET;
    bcd_t SSEC0, SSEC1, SMIN0, SMIN1, SHOUR0, SHOUR1, SDAY0, SDAY1;
    bcd_t SEC0, SEC1, MIN0, MIN1, HOUR0, HOUR1, DAY0, DAY1;
    logic SEC_TICK;
    logic DAY_ROLL;

    modport master (
        output SET, SSEC0, SSEC1, SMIN0, SMIN1, SHOUR0, SHOUR1, SDAY0, SDAY1,
        input  SEC0, SEC1, MIN0, MIN1, HOUR0, HOUR1, DAY0, DAY1, SEC_TICK, DAY_ROLL
    );

    modport slave (
        input  SET, SSEC0, SSEC1, SMIN0, SMIN1, SHOUR0, SHOUR1, SDAY0, SDAY1,
        output SEC0, SEC1, MIN0, MIN1, HOUR0, HOUR1, DAY0, DAY1, SEC_TICK, DAY_ROLL
    );

endinterface

// File: rtl/bcd_field_counter.sv
// Two-digit BCD field: loadable, increments on inc, wraps to MIN_VAL with carry.
module bcd_field_counter
    import clock_pkg::*;
#(
    parameter int unsigned MAX_TENS = 5,
    parameter int unsigned MAX_ONES = 9,
    parameter int unsigned MIN_VAL  = 0,
    parameter int unsigned RST_VAL  = MIN_VAL
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic load,
    input  bcd_t load_tens,
    input  bcd_t load_ones,
    input  logic inc,
    output bcd_t tens,
    output bcd_t ones,
    output logic carry
);

    localparam logic [7:0] MAX_CODE = 8'(MAX_TENS * 10 + MAX_ONES);
    localparam bcd_t MIN_TENS = 4'(MIN_VAL / 10);
    localparam bcd_t MIN_ONES = 4'(MIN_VAL % 10);
    localparam bcd_t RST_TENS = 4'(RST_VAL / 10);
    localparam bcd_t RST_ONES = 4'(RST_VAL % 10);

    logic at_max;
    bcd_t tens_nxt;
    bcd_t ones_nxt;

    // Next value on increment; anything at or beyond the limit (including
    // out-of-range loads) wraps to the minimum.
    always_comb begin
        at_max   = (bcd_value(tens, ones) >= MAX_CODE);
        tens_nxt = tens;
        ones_nxt = ones;
        if (at_max) begin
            tens_nxt = MIN_TENS;
            ones_nxt = MIN_ONES;
        end else if (ones >= 4'd9) begin
            tens_nxt = tens + 4'd1;
            ones_nxt = '0;
        end else begin
            ones_nxt = ones + 4'd1;
        end
    end

    assign carry = inc & at_max;

    // Digit register: reset, then load, then increment.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            tens <= RST_TENS;
            ones <= RST_ONES;
        end else if (load) begin
            tens <= load_tens;
            ones <= load_ones;
        end else if (inc) begin
            tens <= tens_nxt;
            ones <= ones_nxt;
        end
    end

endmodule

// File: rtl/time_counter.sv
// Run-time timekeeping: 1 s prescaler, sec/min/hour/day BCD carry chain, pulses.
module time_counter
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned DAY_MAX  = 31
) (
    input  logic           CLK,
    input  logic           RSTN,
    time_counter_if.slave  bus
);

    localparam int unsigned      CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             c_sec, c_min, c_hour, c_day;
    bcd_t             sec0, sec1, min0, min1, hour0, hour1, day0, day1;
    logic             sec_tick_q, day_roll_q;

    assign tick = !bus.SET && (cnt == CNT_LAST);

    // Prescaler: held at 0 while loading, wraps at TICK_DIV-1.
    always_ff @(posedge CLK) begin
        if (!RSTN || bus.SET) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    bcd_field_counter #(
        .MAX_TENS(SEC_MAX / 10), .MAX_ONES(SEC_MAX % 10), .MIN_VAL(0), .RST_VAL(SEC_RST)
    ) u_sec (
        .CLK(CLK), .RSTN(RSTN), .load(bus.SET), .load_tens(bus.SSEC1), .load_ones(bus.SSEC0),
        .inc(tick), .tens(sec1), .ones(sec0), .carry(c_sec)
    );

    bcd_field_counter #(
        .MAX_TENS(MIN_MAX / 10), .MAX_ONES(MIN_MAX % 10), .MIN_VAL(0), .RST_VAL(MIN_RST)
    ) u_min (
        .CLK(CLK), .RSTN(RSTN), .load(bus.SET), .load_tens(bus.SMIN1), .load_ones(bus.SMIN0),
        .inc(c_sec), .tens(min1), .ones(min0), .carry(c_min)
    );

    bcd_field_counter #(
        .MAX_TENS(HOUR_MAX / 10), .MAX_ONES(HOUR_MAX % 10), .MIN_VAL(0), .RST_VAL(HOUR_RST)
    ) u_hour (
        .CLK(CLK), .RSTN(RSTN), .load(bus.SET), .load_tens(bus.SHOUR1), .load_ones(bus.SHOUR0),
        .inc(c_min), .tens(hour1), .ones(hour0), .carry(c_hour)
    );

    bcd_field_counter #(
        .MAX_TENS(DAY_MAX / 10), .MAX_ONES(DAY_MAX % 10), .MIN_VAL(DAY_MIN), .RST_VAL(DAY_RST)
    ) u_day (
        .CLK(CLK), .RSTN(RSTN), .load(bus.SET), .load_tens(bus.SDAY1), .load_ones(bus.SDAY0),
        .inc(c_hour), .tens(day1), .ones(day0), .carry(c_day)
    );

    // Pulse registers, aligned with the digit update they accompany.
    always_ff @(posedge CLK) begin
        if (!RSTN || bus.SET) begin
            sec_tick_q <= 1'b0;
            day_roll_q <= 1'b0;
        end else begin
            sec_tick_q <= tick;
            day_roll_q <= c_day;
        end
    end

    assign bus.SEC0     = sec0;
    assign bus.SEC1     = sec1;
    assign bus.MIN0     = min0;
    assign bus.MIN1     = min1;
    assign bus.HOUR0    = hour0;
    assign bus.HOUR1    = hour1;
    assign bus.DAY0     = day0;
    assign bus.DAY1     = day1;
    assign bus.SEC_TICK = sec_tick_q;
    assign bus.DAY_ROLL = day_roll_q;

endmodule
